// File: rtl/posit_vector_engine.sv
// Streams posit vectors from a byte-wide read port through an external posit unit into a byte-wide write port.
// Optional cycle counter on io_cycles: define POSIT_VECTOR_ENGINE_PERF_COUNTER_EN.
module posit_vector_engine #(
    parameter int NBITS        = 32,
    parameter int ADDR_W       = 12,
    parameter int CNT_W        = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_start,
    input  logic              io_mode,
    input  logic [1:0]        io_op,
    input  logic [CNT_W-1:0]  io_count,
    input  logic [ADDR_W-1:0] io_a_address,
    input  logic [ADDR_W-1:0] io_b_address,
    input  logic [ADDR_W-1:0] io_result_address,
    output logic [ADDR_W-1:0] io_address_to_read,
    input  logic [7:0]        io_read_data,
    output logic [ADDR_W-1:0] io_address_to_write,
    output logic [7:0]        io_write_data,
    output logic              io_write_enable,
    output logic [NBITS-1:0]  io_unit_a,
    output logic [NBITS-1:0]  io_unit_b,
    output logic [1:0]        io_unit_op,
    output logic              io_unit_valid,
    input  logic              io_unit_ready,
    input  logic              io_unit_res_valid,
    input  logic [NBITS-1:0]  io_unit_res,
    output logic              io_completed,
    output logic [NBITS-1:0]  io_result,
    output logic [31:0]       io_cycles
);
    localparam int BYTES = NBITS / 8;
    localparam int CW    = $clog2(BYTES + READ_LATENCY + 1);
    localparam logic [CW-1:0] RD_LAST = CW'(BYTES + READ_LATENCY - 1);
    localparam logic [CW-1:0] RL_C    = CW'(READ_LATENCY);
    localparam logic [CW-1:0] WR_LAST = CW'(BYTES - 1);

    typedef enum logic [2:0] {S_IDLE, S_RD_A, S_RD_B, S_ISSUE, S_WAIT, S_WR, S_DONE} state_t;

    state_t            state_q;
    logic              mode_q, valid_q, we_q, done_q;
    logic [1:0]        op_q;
    logic [CNT_W-1:0]  count_q, i_q;
    logic [ADDR_W-1:0] a_base_q, b_base_q, r_base_q, off_q, rd_addr_q, waddr_q;
    logic [CW-1:0]     cnt_q;
    logic [NBITS-1:0]  opa_q, opb_q, res_q, wsh_q;
    logic [7:0]        wdata_q;

    // Bytes arrive least-significant first, so each new byte enters at the top.
    function automatic logic [NBITS-1:0] shift_in(input logic [NBITS-1:0] cur, input logic [7:0] b);
        logic [NBITS-1:0] t;
        t = cur >> 8;
        t[NBITS-1 -: 8] = b;
        return t;
    endfunction

    logic [CNT_W:0]    i_d;
    logic              more_elems;
    logic [ADDR_W-1:0] off_d, wr_addr_d;
    logic [NBITS-1:0]  wr_val_d;

    always_comb begin
        i_d        = {1'b0, i_q} + 1'b1;
        more_elems = i_d < {1'b0, count_q};
        off_d      = off_q + ADDR_W'(BYTES);
        wr_val_d   = (state_q == S_WAIT) ? io_unit_res : shift_in(opa_q, io_read_data);
        wr_addr_d  = mode_q ? r_base_q : r_base_q + off_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            mode_q    <= 1'b0;
            valid_q   <= 1'b0;
            we_q      <= 1'b0;
            done_q    <= 1'b0;
            op_q      <= '0;
            count_q   <= '0;
            i_q       <= '0;
            a_base_q  <= '0;
            b_base_q  <= '0;
            r_base_q  <= '0;
            off_q     <= '0;
            rd_addr_q <= '0;
            waddr_q   <= '0;
            cnt_q     <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            res_q     <= '0;
            wsh_q     <= '0;
            wdata_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (io_start) begin
                    mode_q    <= io_mode;
                    op_q      <= io_op;
                    count_q   <= io_count;
                    a_base_q  <= io_a_address;
                    b_base_q  <= io_b_address;
                    r_base_q  <= io_result_address;
                    i_q       <= '0;
                    off_q     <= '0;
                    cnt_q     <= '0;
                    rd_addr_q <= io_a_address;
                    if (io_count == '0) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= S_RD_A;
                    end
                end
                S_RD_A, S_RD_B: begin
                    rd_addr_q <= rd_addr_q + 1'b1;
                    cnt_q     <= cnt_q + 1'b1;
                    // Reduction: element 0 seeds the accumulator (opa), later elements feed operand b.
                    if (cnt_q >= RL_C) begin
                        if (state_q == S_RD_B || (mode_q && i_q != '0))
                            opb_q <= shift_in(opb_q, io_read_data);
                        else
                            opa_q <= shift_in(opa_q, io_read_data);
                    end
                    if (cnt_q == RD_LAST) begin
                        cnt_q <= '0;
                        if (state_q == S_RD_A && !mode_q) begin
                            state_q   <= S_RD_B;
                            rd_addr_q <= b_base_q + off_q;
                        end else if (mode_q && i_q == '0) begin
                            if (count_q == CNT_W'(1)) begin
                                res_q   <= wr_val_d;
                                state_q <= S_WR;
                                we_q    <= 1'b1;
                                waddr_q <= wr_addr_d;
                                wdata_q <= wr_val_d[7:0];
                                wsh_q   <= wr_val_d >> 8;
                            end else begin
                                i_q       <= CNT_W'(1);
                                off_q     <= off_d;
                                rd_addr_q <= a_base_q + off_d;
                            end
                        end else begin
                            state_q <= S_ISSUE;
                            valid_q <= 1'b1;
                        end
                    end
                end
                S_ISSUE: if (io_unit_ready) begin
                    valid_q <= 1'b0;
                    state_q <= S_WAIT;
                end
                S_WAIT: if (io_unit_res_valid) begin
                    res_q <= io_unit_res;
                    if (mode_q) opa_q <= io_unit_res;
                    if (mode_q && more_elems) begin
                        i_q       <= i_d[CNT_W-1:0];
                        off_q     <= off_d;
                        rd_addr_q <= a_base_q + off_d;
                        cnt_q     <= '0;
                        state_q   <= S_RD_A;
                    end else begin
                        state_q <= S_WR;
                        we_q    <= 1'b1;
                        waddr_q <= wr_addr_d;
                        wdata_q <= wr_val_d[7:0];
                        wsh_q   <= wr_val_d >> 8;
                        cnt_q   <= '0;
                    end
                end
                S_WR: begin
                    if (cnt_q == WR_LAST) begin
                        we_q  <= 1'b0;
                        cnt_q <= '0;
                        if (!mode_q && more_elems) begin
                            i_q       <= i_d[CNT_W-1:0];
                            off_q     <= off_d;
                            rd_addr_q <= a_base_q + off_d;
                            state_q   <= S_RD_A;
                        end else begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        cnt_q   <= cnt_q + 1'b1;
                        waddr_q <= waddr_q + 1'b1;
                        wdata_q <= wsh_q[7:0];
                        wsh_q   <= wsh_q >> 8;
                    end
                end
                S_DONE: if (!io_start) begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef POSIT_VECTOR_ENGINE_PERF_COUNTER_EN
    logic [31:0] cyc_q;
    always_ff @(posedge clock) begin
        if (reset)
            cyc_q <= '0;
        else if (state_q == S_IDLE && io_start)
            cyc_q <= '0;
        else if (state_q != S_IDLE && state_q != S_DONE && cyc_q != '1)
            cyc_q <= cyc_q + 1'b1;
    end
    assign io_cycles = cyc_q;
`else
    assign io_cycles = '0;
`endif

    assign io_address_to_read  = rd_addr_q;
    assign io_address_to_write = waddr_q;
    assign io_write_data       = wdata_q;
    assign io_write_enable     = we_q;
    assign io_unit_a           = opa_q;
    assign io_unit_b           = opb_q;
    assign io_unit_op          = op_q;
    assign io_unit_valid       = valid_q;
    assign io_completed        = done_q;
    assign io_result           = res_q;
endmodule
